// File: rtl/sisc_defs.sv
// Shared SISC definitions: instruction field positions, opcodes and fetch state encoding.
package sisc_defs;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_IMM_W  = 16;

  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 28;
  localparam int unsigned MM_HI  = 27;
  localparam int unsigned MM_LO  = 24;

  localparam logic [3:0] OP_NOOP = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SHFT = 4'h7;
  localparam logic [3:0] OP_BRA  = 4'h8;
  localparam logic [3:0] OP_BRR  = 4'h9;
  localparam logic [3:0] OP_LOD  = 4'hA;
  localparam logic [3:0] OP_STR  = 4'hB;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/sisc_branch_target.sv
// Branch target: absolute immediate, or PC plus sign-extended immediate (wraps mod 2^ADDR_W).
module sisc_branch_target
  import sisc_defs::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned IMM_W  = DEF_IMM_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [IMM_W-1:0]  imm,
  input  logic              br_sel,
  output logic [ADDR_W-1:0] target_c
);

  logic [ADDR_W-1:0] imm_abs;
  logic [ADDR_W-1:0] imm_sext;

  always_comb begin
    imm_abs  = ADDR_W'(imm);
    imm_sext = ADDR_W'($signed(imm));
    target_c = br_sel ? imm_abs : (pc + imm_sext);
  end

endmodule

// File: rtl/sisc_fetch_unit.sv
// SISC fetch unit: owns PC and IR, runs the instruction-memory handshake for the control FSM.
module sisc_fetch_unit
  import sisc_defs::*;
#(
  parameter int unsigned       DATA_W   = DEF_DATA_W,
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter int unsigned       IMM_W    = DEF_IMM_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_rst,
  input  logic              pc_write,
  input  logic              pc_sel,
  input  logic              br_sel,
  input  logic              ir_load,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [3:0]        opcode,
  output logic [3:0]        mm,
  output logic [ADDR_W-1:0] pc,
  output logic              ir_valid,
  output logic              fetch_busy,
  output logic              proto_err
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              busy_q, busy_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              inc_q, inc_d;
  logic              complete;
  logic [ADDR_W-1:0] br_target;

  sisc_branch_target #(
    .ADDR_W (ADDR_W),
    .IMM_W  (IMM_W)
  ) u_branch_target (
    .pc       (pc_q),
    .imm      (ir_q[IMM_W-1:0]),
    .br_sel   (br_sel),
    .target_c (br_target)
  );

  // Next-state logic; pc_rst overrides everything and drains an in-flight response.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = 1'b0;
    busy_d     = busy_q;
    req_d      = req_q;
    addr_d     = addr_q;
    err_d      = err_q;
    inc_d      = inc_q;
    complete   = 1'b0;

    if (pc_rst) begin
      pc_d    = RESET_PC;
      req_d   = 1'b0;
      busy_d  = 1'b0;
      state_d = ST_IDLE;
      case (state_q)
        ST_WAIT:  if (!mem_rvalid) state_d = ST_DRAIN;
        ST_REQ:   if (mem_gnt && !mem_rvalid) state_d = ST_DRAIN;
        ST_DRAIN: if (!mem_rvalid) state_d = ST_DRAIN;
        default:  state_d = ST_IDLE;
      endcase
    end else begin
      if (pc_write && busy_q) err_d = 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (mem_rvalid) err_d = 1'b1;
          if (pc_write && pc_sel) pc_d = br_target;
          if (ir_load) begin
            addr_d  = pc_q;
            req_d   = 1'b1;
            busy_d  = 1'b1;
            inc_d   = pc_write & ~pc_sel;
            state_d = ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            req_d = 1'b0;
            if (mem_rvalid) complete = 1'b1;
            else            state_d  = ST_WAIT;
          end else if (mem_rvalid) begin
            err_d = 1'b1;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) complete = 1'b1;
        end
        ST_DRAIN: begin
          if (ir_load)    err_d   = 1'b1;
          if (mem_rvalid) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase

      if (complete) begin
        ir_d       = mem_rdata;
        ir_valid_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
        if (inc_q) pc_d = pc_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      err_q      <= 1'b0;
      inc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      busy_q     <= busy_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
      inc_q      <= inc_d;
    end
  end

  assign mem_req    = req_q;
  assign mem_addr   = addr_q;
  assign ir         = ir_q;
  assign opcode     = ir_q[OPC_HI:OPC_LO];
  assign mm         = ir_q[MM_HI:MM_LO];
  assign pc         = pc_q;
  assign ir_valid   = ir_valid_q;
  assign fetch_busy = busy_q;
  assign proto_err  = err_q;

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Directed bench for sisc_fetch_unit: vector table plus hand-written multi-cycle sequences.
module tb_sisc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, pc_rst, pc_write, pc_sel, br_sel, ir_load;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [15:0] mem_addr, pc;
  logic [31:0] mem_rdata, ir;
  logic [3:0]  opcode, mm;
  logic        ir_valid, fetch_busy, proto_err;

  int n_chk = 0;
  int n_err = 0;

  sisc_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .pc_rst     (pc_rst),
    .pc_write   (pc_write),
    .pc_sel     (pc_sel),
    .br_sel     (br_sel),
    .ir_load    (ir_load),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .ir         (ir),
    .opcode     (opcode),
    .mm         (mm),
    .pc         (pc),
    .ir_valid   (ir_valid),
    .fetch_busy (fetch_busy),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld, pw, ps, bs, gnt, rv;
    logic [31:0] rd;
    logic [15:0] e_pc;
    logic [31:0] e_ir;
    logic [15:0] e_addr;
    logic        e_req, e_busy, e_irv;
  } vec_t;

  function automatic vec_t mk(input logic ld, pw, ps, bs, gnt, rv, input logic [31:0] rd,
                              input logic [15:0] e_pc, input logic [31:0] e_ir,
                              input logic [15:0] e_addr, input logic e_req, e_busy, e_irv);
    vec_t v;
    v.ld = ld; v.pw = pw; v.ps = ps; v.bs = bs; v.gnt = gnt; v.rv = rv; v.rd = rd;
    v.e_pc = e_pc; v.e_ir = e_ir; v.e_addr = e_addr;
    v.e_req = e_req; v.e_busy = e_busy; v.e_irv = e_irv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_rst = 0; pc_write = 0; pc_sel = 0; br_sel = 0; ir_load = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  vec_t vecs[18];
  int   busy_cnt;
  int   irv_cnt;

  initial begin
    // ld pw ps bs gnt rv rdata            pc       ir             addr     req busy irv
    vecs[0]  = mk(1,1,0,0, 0,0, 32'h0,         16'h0000, 32'h0,         16'h0000, 1,1,0);
    vecs[1]  = mk(0,0,0,0, 1,1, 32'h8100_0003, 16'h0001, 32'h8100_0003, 16'h0000, 0,0,1);
    vecs[2]  = mk(1,0,0,0, 0,0, 32'h0,         16'h0001, 32'h8100_0003, 16'h0001, 1,1,0);
    vecs[3]  = mk(0,0,0,0, 1,1, 32'h8100_0010, 16'h0001, 32'h8100_0010, 16'h0001, 0,0,1);
    vecs[4]  = mk(0,1,1,1, 0,0, 32'h0,         16'h0010, 32'h8100_0010, 16'h0001, 0,0,0);
    vecs[5]  = mk(1,0,0,0, 0,0, 32'h0,         16'h0010, 32'h8100_0010, 16'h0010, 1,1,0);
    vecs[6]  = mk(0,0,0,0, 1,1, 32'h9000_FFF0, 16'h0010, 32'h9000_FFF0, 16'h0010, 0,0,1);
    vecs[7]  = mk(0,1,1,0, 0,0, 32'h0,         16'h0000, 32'h9000_FFF0, 16'h0010, 0,0,0);
    vecs[8]  = mk(1,0,0,0, 0,0, 32'h0,         16'h0000, 32'h9000_FFF0, 16'h0000, 1,1,0);
    vecs[9]  = mk(0,0,0,0, 1,1, 32'h8000_0042, 16'h0000, 32'h8000_0042, 16'h0000, 0,0,1);
    vecs[10] = mk(0,1,1,1, 0,0, 32'h0,         16'h0042, 32'h8000_0042, 16'h0000, 0,0,0);
    vecs[11] = mk(1,0,0,0, 0,0, 32'h0,         16'h0042, 32'h8000_0042, 16'h0042, 1,1,0);
    vecs[12] = mk(0,0,0,0, 1,1, 32'h8000_FFFF, 16'h0042, 32'h8000_FFFF, 16'h0042, 0,0,1);
    vecs[13] = mk(0,1,1,1, 0,0, 32'h0,         16'hFFFF, 32'h8000_FFFF, 16'h0042, 0,0,0);
    vecs[14] = mk(1,1,0,0, 0,0, 32'h0,         16'hFFFF, 32'h8000_FFFF, 16'hFFFF, 1,1,0);
    vecs[15] = mk(0,0,0,0, 1,1, 32'h1234_5678, 16'h0000, 32'h1234_5678, 16'hFFFF, 0,0,1);
    vecs[16] = mk(1,0,0,0, 0,0, 32'h0,         16'h0000, 32'h1234_5678, 16'h0000, 1,1,0);
    vecs[17] = mk(0,0,0,0, 1,1, 32'hA000_0000, 16'h0000, 32'hA000_0000, 16'h0000, 0,0,1);

    do_reset();
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_flags", {28'h0, mem_req, fetch_busy, ir_valid, proto_err}, 32'h0);

    for (int i = 0; i < 18; i++) begin
      ir_load = vecs[i].ld; pc_write = vecs[i].pw; pc_sel = vecs[i].ps; br_sel = vecs[i].bs;
      mem_gnt = vecs[i].gnt; mem_rvalid = vecs[i].rv; mem_rdata = vecs[i].rd;
      step();
      chk($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].e_pc));
      chk($sformatf("v%0d_ir", i), ir, vecs[i].e_ir);
      chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
      chk($sformatf("v%0d_req", i), 32'(mem_req), 32'(vecs[i].e_req));
      chk($sformatf("v%0d_busy", i), 32'(fetch_busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d_irv", i), 32'(ir_valid), 32'(vecs[i].e_irv));
      chk($sformatf("v%0d_err", i), 32'(proto_err), 32'h0);
      if (i == 1) begin
        chk("v1_opcode", 32'(opcode), 32'h8);
        chk("v1_mm", 32'(mm), 32'h1);
      end
    end
    idle_inputs();

    // Slow memory: grant after three waiting cycles, data two cycles after grant.
    busy_cnt = 0;
    irv_cnt  = 0;
    ir_load = 1; pc_write = 1; pc_sel = 0;
    step();
    idle_inputs();
    busy_cnt += int'(fetch_busy);
    for (int c = 0; c < 3; c++) begin
      step();
      busy_cnt += int'(fetch_busy);
      chk($sformatf("slow_req%0d", c), 32'(mem_req), 32'h1);
      chk($sformatf("slow_addr%0d", c), 32'(mem_addr), 32'h0);
    end
    mem_gnt = 1;
    step();
    mem_gnt = 0;
    busy_cnt += int'(fetch_busy);
    chk("slow_req_after_gnt", 32'(mem_req), 32'h0);
    step();
    busy_cnt += int'(fetch_busy);
    chk("slow_addr_wait", 32'(mem_addr), 32'h0);
    mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
    step();
    idle_inputs();
    busy_cnt += int'(fetch_busy);
    irv_cnt  += int'(ir_valid);
    chk("slow_ir", ir, 32'h5555_AAAA);
    chk("slow_pc_inc", 32'(pc), 32'h1);
    for (int c = 0; c < 3; c++) begin
      step();
      busy_cnt += int'(fetch_busy);
      irv_cnt  += int'(ir_valid);
    end
    chk("slow_busy_cycles", 32'(busy_cnt), 32'd6);
    chk("slow_irv_pulses", 32'(irv_cnt), 32'd1);

    // Abort in WAIT: late response must be discarded.
    ir_load = 1;
    step();
    ir_load = 0; mem_gnt = 1;
    step();
    mem_gnt = 0; pc_rst = 1;
    step();
    pc_rst = 0;
    chk("abort_pc", 32'(pc), 32'h0);
    chk("abort_busy_req", {30'h0, fetch_busy, mem_req}, 32'h0);
    mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    step();
    idle_inputs();
    chk("drain_ir", ir, 32'h5555_AAAA);
    chk("drain_irv", 32'(ir_valid), 32'h0);
    ir_load = 1;
    step();
    ir_load = 0;
    chk("post_drain_req", 32'(mem_req), 32'h1);
    chk("post_drain_addr", 32'(mem_addr), 32'h0);
    mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h1111_2222;
    step();
    idle_inputs();
    chk("post_drain_ir", ir, 32'h1111_2222);
    chk("post_drain_err", 32'(proto_err), 32'h0);

    // Stray response in IDLE sets a sticky error that only rst clears.
    mem_rvalid = 1; mem_rdata = 32'hCAFE_0000;
    step();
    idle_inputs();
    chk("stray_err", 32'(proto_err), 32'h1);
    chk("stray_ir", ir, 32'h1111_2222);
    pc_rst = 1;
    step();
    pc_rst = 0;
    step();
    chk("stray_sticky", 32'(proto_err), 32'h1);
    do_reset();
    chk("rst_clears_err", 32'(proto_err), 32'h0);
    chk("rst_clears_ir", ir, 32'h0);

    // pc_write while busy is ignored and flagged.
    ir_load = 1;
    step();
    ir_load = 0; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h8000_0077;
    step();
    idle_inputs();
    ir_load = 1;
    step();
    ir_load = 0; pc_write = 1; pc_sel = 1; br_sel = 1;
    step();
    idle_inputs();
    chk("busy_pw_pc", 32'(pc), 32'h0);
    chk("busy_pw_err", 32'(proto_err), 32'h1);
    mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h8000_0033;
    step();
    idle_inputs();
    chk("busy_pw_ir", ir, 32'h8000_0033);
    pc_write = 1; pc_sel = 1; br_sel = 1;
    step();
    idle_inputs();
    chk("idle_branch_pc", 32'(pc), 32'h0033);
    chk("err_still_set", 32'(proto_err), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
